// File: rtl/wb_map_pkg.sv
// wb_map_pkg: slave address map, error data word and interconnect FSM states
package wb_map_pkg;
  localparam int N_MAP = 8;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  // Entries 4..7 use mask 0 with base 1, so they can never match
  localparam logic [31:0] MAP_BASE [N_MAP] = '{
    32'h8000_0000, 32'h2000_0000, 32'h2000_1000, 32'h2000_2000,
    32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001
  };
  localparam logic [31:0] MAP_MASK [N_MAP] = '{
    32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
  };
  typedef enum logic [1:0] {IDLE, BUSY, ERR_ACK} state_t;
endpackage

// File: rtl/wb_addr_decoder.sv
// wb_addr_decoder: first-match address decode into a one-hot slave hit plus valid
module wb_addr_decoder
  import wb_map_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [31:0]  adr,
  output logic [N-1:0] hit,
  output logic         valid
);
  always_comb begin
    hit = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++)
      if (!valid && (adr & MAP_MASK[i]) == MAP_BASE[i]) begin
        hit[i] = 1'b1;
        valid = 1'b1;
      end
  end
endmodule

// File: rtl/wb_interconnect.sv
// wb_interconnect: single-master Wishbone interconnect with address decode,
// ack timeout and a sticky bus-error record
module wb_interconnect
  import wb_map_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            m_adr_i,
  input  logic [31:0]            m_dat_i,
  input  logic [3:0]             m_sel_i,
  input  logic                   m_we_i,
  input  logic                   m_cyc_i,
  input  logic                   m_stb_i,
  output logic [31:0]            m_dat_o,
  output logic                   m_ack_o,
  output logic [31:0]            s_adr_o,
  output logic [31:0]            s_dat_o,
  output logic [3:0]             s_sel_o,
  output logic                   s_we_o,
  output logic [N_SLAVES-1:0]    s_cyc_o,
  output logic [N_SLAVES-1:0]    s_stb_o,
  input  logic [N_SLAVES*32-1:0] s_dat_i,
  input  logic [N_SLAVES-1:0]    s_ack_i,
  output logic                   bus_err_o,
  output logic [31:0]            err_adr_o,
  input  logic                   err_clr_i
);
  localparam int IW = $clog2(N_SLAVES);
  state_t state, nxt;
  logic [IW-1:0] idx, hit_idx;
  logic [9:0] cnt;
  logic [N_SLAVES-1:0] hit;
  logic valid, req, sel_ack, tmo, live;
  logic [31:0] sd [N_SLAVES];
  wb_addr_decoder #(.N(N_SLAVES)) u_dec (.adr(m_adr_i), .hit(hit), .valid(valid));
  for (genvar i = 0; i < N_SLAVES; i++) begin : g_sd
    assign sd[i] = s_dat_i[32*i +: 32];
  end
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < N_SLAVES; i++)
      if (hit[i]) hit_idx = IW'(i);
  end
  assign req     = m_cyc_i & m_stb_i;
  assign sel_ack = s_ack_i[idx];
  assign tmo     = cnt == 10'(TIMEOUT - 1);
  assign live    = state == BUSY && m_cyc_i;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = IDLE;
    if (state == IDLE) nxt = req ? (valid ? BUSY : ERR_ACK) : IDLE;
    else if (state == BUSY) nxt = (!m_cyc_i || sel_ack) ? IDLE : (tmo ? ERR_ACK : BUSY);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idx <= '0;
      cnt <= '0;
    end else begin
      idx <= (state == IDLE && req && valid) ? hit_idx : idx;
      cnt <= (live && !sel_ack) ? cnt + 10'd1 : '0;
    end
  // A clear coinciding with a new error lets the new error's address in
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus_err_o <= 1'b0;
      err_adr_o <= '0;
    end else if (state == ERR_ACK) begin
      bus_err_o <= 1'b1;
      if (!bus_err_o || err_clr_i) err_adr_o <= m_adr_i;
    end else if (err_clr_i) begin
      bus_err_o <= 1'b0;
      err_adr_o <= '0;
    end
  always_comb begin
    s_cyc_o = live ? N_SLAVES'(1) << idx : '0;
    s_stb_o = s_cyc_o;
    m_ack_o = state == ERR_ACK || (live && sel_ack);
    m_dat_o = state == ERR_ACK ? ERR_DATA : (live && sel_ack) ? sd[idx] : '0;
  end
  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_sel_o = m_sel_i;
  assign s_we_o  = m_we_i;
endmodule

// File: tb/tb_wb_interconnect.sv
// tb_wb_interconnect: directed vectors checked against a transaction-level model every cycle
module tb_wb_interconnect;
  localparam int TMO = 8;
  logic clk = 1'b0, reset_n;
  logic [31:0] m_adr = '0, m_dat = '0;
  logic [3:0] m_sel = 4'hF;
  logic m_we = 1'b0, m_cyc = 1'b0, m_stb = 1'b0, err_clr = 1'b0;
  logic [31:0] m_dat_o, s_adr_o, s_dat_o, err_adr_o;
  logic m_ack_o, s_we_o, bus_err_o;
  logic [3:0] s_sel_o, s_cyc_o, s_stb_o, s_ack = '0;
  logic [31:0] sd [4] = '{32'h1234_5678, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
  int n_vec = 0, n_err = 0;
  int tgt = -1, waited = 0;
  bit err_now = 0, err_flag = 0;
  logic [31:0] err_addr = '0;

  wb_interconnect #(.N_SLAVES(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i({sd[3], sd[2], sd[1], sd[0]}),
    .s_ack_i(s_ack), .bus_err_o(bus_err_o), .err_adr_o(err_adr_o), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    if (a[31:28] == 4'h8) return 0;
    if (a[31:12] == 20'h20000) return 1;
    if (a[31:12] == 20'h20001) return 2;
    if (a[31:12] == 20'h20002) return 3;
    return -1;
  endfunction

  // Model: tgt = slave currently owning the bus (-1 none), err_now = error ack due this cycle
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt <= -1; waited <= 0; err_now <= 0; err_flag <= 0; err_addr <= '0;
    end else begin
      if (err_now) begin
        err_now <= 0;
        err_flag <= 1;
        if (!err_flag || err_clr) err_addr <= m_adr;
      end else if (err_clr) begin
        err_flag <= 0; err_addr <= '0;
      end
      if (tgt >= 0) begin
        if (!m_cyc || s_ack[tgt]) tgt <= -1;
        else if (waited + 1 == TMO) begin tgt <= -1; err_now <= 1; end
        else waited <= waited + 1;
      end else if (!err_now && m_cyc && m_stb) begin
        if (decode(m_adr) >= 0) begin tgt <= decode(m_adr); waited <= 0; end
        else err_now <= 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] e_stb;
    logic e_ack;
    logic [31:0] e_dat;
    e_stb = (tgt >= 0 && m_cyc) ? 4'(1 << tgt) : 4'h0;
    e_ack = err_now ? 1'b1 : (tgt >= 0 && m_cyc) ? s_ack[tgt] : 1'b0;
    e_dat = err_now ? 32'hDEAD_BEEF : (e_ack ? sd[tgt] : 32'h0);
    chk("m_ack", {31'b0, m_ack_o}, {31'b0, e_ack});
    chk("m_dat", m_dat_o, e_dat);
    chk("s_cyc", {28'b0, s_cyc_o}, {28'b0, e_stb});
    chk("s_stb", {28'b0, s_stb_o}, {28'b0, e_stb});
    chk("s_adr", s_adr_o, m_adr);
    chk("s_dat", s_dat_o, m_dat);
    chk("s_sel_we", {27'b0, s_we_o, s_sel_o}, {27'b0, m_we, m_sel});
    chk("bus_err", {31'b0, bus_err_o}, {31'b0, err_flag});
    chk("err_adr", err_adr_o, err_addr);
  end

  task automatic drv(input bit c, input logic [31:0] a, input bit w = 0, input logic [31:0] d = 0,
                     input logic [3:0] sl = 4'hF, input logic [3:0] ak = 4'h0, input bit clr = 0);
    @(posedge clk);
    #1;
    m_cyc = c; m_stb = c; m_adr = a; m_we = w; m_dat = d; m_sel = sl; s_ack = ak; err_clr = clr;
    #1;
  endtask

  initial begin
    int ack_at;
    reset_n = 1'b0;
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h8000_0000;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ack", {31'b0, m_ack_o}, 32'd0);
    chk("rst_cyc", {28'b0, s_cyc_o}, 32'd0);
    chk("rst_err", {bus_err_o, err_adr_o[30:0]}, 32'd0);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    // Read slave 0 with one-cycle ack
    drv(1, 32'h8000_0010);
    chk("rd_idle_ack", {31'b0, m_ack_o}, 32'd0);
    drv(1, 32'h8000_0010, 0, 0, 4'hF, 4'b0001);
    chk("rd_ack", {31'b0, m_ack_o}, 32'd1);
    chk("rd_dat", m_dat_o, 32'h1234_5678);
    chk("rd_stb", {28'b0, s_stb_o}, 32'b0001);
    drv(0, 32'h0);
    // Write slave 2 with stray slave-1 ack, then back-to-back read of slave 3
    drv(1, 32'h2000_1004, 1, 32'hA5, 4'b0001, 4'b0010);
    drv(1, 32'h2000_1004, 1, 32'hA5, 4'b0001, 4'b0010);
    chk("wr_stray_ack", {31'b0, m_ack_o}, 32'd0);
    chk("wr_stb", {28'b0, s_stb_o}, 32'b0100);
    chk("wr_dat", s_dat_o, 32'hA5);
    chk("wr_sel", {28'b0, s_sel_o}, 32'b0001);
    drv(1, 32'h2000_1004, 1, 32'hA5, 4'b0001, 4'b0100);
    chk("wr_ack", {31'b0, m_ack_o}, 32'd1);
    drv(1, 32'h2000_2000);
    chk("b2b_bubble", {31'b0, m_ack_o}, 32'd0);
    drv(1, 32'h2000_2000, 0, 0, 4'hF, 4'b1000);
    chk("b2b_dat", m_dat_o, 32'h3333_3333);
    drv(0, 32'h0);
    // Unmapped access
    drv(1, 32'h4000_0000);
    drv(1, 32'h4000_0000);
    chk("um_ack", {31'b0, m_ack_o}, 32'd1);
    chk("um_dat", m_dat_o, 32'hDEAD_BEEF);
    drv(0, 32'h0);
    chk("um_err", {31'b0, bus_err_o}, 32'd1);
    chk("um_adr", err_adr_o, 32'h4000_0000);
    drv(0, 32'h0, 0, 0, 4'hF, 4'h0, 1);
    drv(0, 32'h0);
    chk("clr_err", {31'b0, bus_err_o}, 32'd0);
    chk("clr_adr", err_adr_o, 32'h0);
    // Slave 1 never acks: timeout error ack after TMO busy cycles
    ack_at = -1;
    drv(1, 32'h2000_0000);
    for (int k = 1; k <= TMO + 1; k++) begin
      drv(1, 32'h2000_0000);
      if (m_ack_o && ack_at < 0) ack_at = k;
      if (k == TMO) chk("tmo_stb", {28'b0, s_stb_o}, 32'b0010);
    end
    chk("tmo_lat", ack_at, TMO + 1);
    chk("tmo_dat", m_dat_o, 32'hDEAD_BEEF);
    chk("tmo_stb_drop", {28'b0, s_stb_o}, 32'd0);
    drv(0, 32'h0);
    chk("tmo_adr", err_adr_o, 32'h2000_0000);
    drv(1, 32'h4000_0004);
    drv(1, 32'h4000_0004);
    drv(0, 32'h0);
    chk("keep_first", err_adr_o, 32'h2000_0000);
    drv(1, 32'h4000_0008);
    drv(1, 32'h4000_0008, 0, 0, 4'hF, 4'h0, 1);
    drv(0, 32'h0);
    chk("clr_vs_new", {bus_err_o, err_adr_o[30:0]}, 32'hC000_0008);
    drv(0, 32'h0, 0, 0, 4'hF, 4'h0, 1);
    drv(0, 32'h0);
    chk("clr2", {31'b0, bus_err_o}, 32'd0);
    // Master abort, then reset mid-transaction
    drv(1, 32'h8000_0020);
    drv(1, 32'h8000_0020);
    drv(0, 32'h8000_0020, 0, 0, 4'hF, 4'b0001);
    chk("abort_ack", {31'b0, m_ack_o}, 32'd0);
    chk("abort_cyc", {28'b0, s_cyc_o}, 32'd0);
    drv(0, 32'h0);
    drv(1, 32'h8000_0030);
    drv(1, 32'h8000_0030);
    chk("pre_rst_cyc", {28'b0, s_cyc_o}, 32'b0001);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cyc", {28'b0, s_cyc_o}, 32'd0);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    drv(1, 32'h2000_1000);
    chk("post_rst_ack", {31'b0, m_ack_o}, 32'd0);
    drv(1, 32'h2000_1000, 0, 0, 4'hF, 4'b0100);
    chk("post_rst_dat", m_dat_o, 32'h2222_2222);
    drv(0, 32'h0);
    drv(0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
